// File: rtl/rip_ro_bank.sv
// Ring-oscillator bank: per-channel edge counting over a programmable clk window
// plus an XOR-of-rings entropy harvester. Each ring is a clk-stepped stand-in.
`timescale 1ns/1ps

module rip_ring_oscillator #(
    parameter int SIZE           = 3,
    parameter int INVERTER_DELAY = 10
) (
    input  logic clk,
    input  logic rstn,
    output logic ro_out
);
    // Each inverter's delay is expressed in 10 ns clk ticks so the ring steps without delays.
    localparam int STAGE_CYC = (INVERTER_DELAY >= 10) ? (INVERTER_DELAY / 10) : 1;
    localparam int LEN       = SIZE * STAGE_CYC;

    logic [LEN-1:0] r_line;

    // Inverting loop: output half-period is LEN ticks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_line <= '0;
        end else begin
            r_line <= {r_line[LEN-2:0], ~r_line[LEN-1]};
        end
    end

    assign ro_out = r_line[LEN-1];
endmodule

module rip_ro_bank #(
    parameter int N_CH           = 4,
    parameter int RO_BASE_SIZE   = 3,
    parameter int INVERTER_DELAY = 10,
    parameter int WIN_W          = 16,
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int RND_W          = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [WIN_W-1:0]        window,
    input  logic [N_CH-1:0]         ch_en,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH*CNT_W-1:0]   counts,
    output logic [N_CH-1:0]         overflow,
    output logic [RND_W-1:0]        rnd,
    output logic                    rnd_valid
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int                BC_W        = $clog2(RND_W + 1);
    localparam logic [WIN_W-1:0]  SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [BC_W-1:0]   BIT_LAST    = BC_W'(RND_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t                       r_state, w_next;
    logic [WIN_W-1:0]             r_tcnt, w_tcnt_next, r_win;
    logic [N_CH-1:0]              r_en, r_sync1, r_sync2, r_prev, r_ovf;
    logic [N_CH-1:0]              w_ring, w_ring_rstn, w_edge;
    logic [N_CH-1:0][CNT_W-1:0]   r_cnt;
    logic [RND_W-2:0]             r_shift;
    logic [BC_W-1:0]              r_bitcnt;
    logic [RND_W-1:0]             r_rnd, w_word;
    logic                         r_busy, r_done, r_rnd_valid;
    logic                         w_run, w_accept, w_measure, w_bit;

    assign w_run     = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_measure = (r_state == ST_MEASURE);
    assign w_edge    = r_sync2 & ~r_prev & r_en;
    assign w_bit     = ^(r_sync2 & r_en);
    assign w_word    = {r_shift, w_bit};

    for (genvar i = 0; i < N_CH; i++) begin : g_ring
        assign w_ring_rstn[i] = rstn & r_en[i] & w_run;
        rip_ring_oscillator #(
            .SIZE           (RO_BASE_SIZE + 2 * i),
            .INVERTER_DELAY (INVERTER_DELAY)
        ) u_ring (
            .clk    (clk),
            .rstn   (w_ring_rstn[i]),
            .ro_out (w_ring[i])
        );
    end

    // Next-state and phase-counter logic.
    always_comb begin
        w_next      = r_state;
        w_tcnt_next = r_tcnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_SETTLE;
                    w_tcnt_next = '0;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_tcnt == SETTLE_LAST) begin
                    w_tcnt_next = '0;
                    w_next      = (r_win == '0) ? ST_DONE : ST_MEASURE;
                end else begin
                    w_tcnt_next = r_tcnt + WIN_W'(1);
                end
            end
            ST_MEASURE: begin
                if (r_tcnt == (r_win - WIN_W'(1))) begin
                    w_tcnt_next = '0;
                    w_next      = ST_DONE;
                end else begin
                    w_tcnt_next = r_tcnt + WIN_W'(1);
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next      = ST_IDLE;
                w_tcnt_next = '0;
            end
        endcase
    end

    // State, phase counter, latched configuration and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
            r_win   <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= w_tcnt_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            if (w_accept) begin
                r_win <= window;
                r_en  <= ch_en;
            end
        end
    end

    // Prev flop tracks sync in every state so entering MEASURE never fakes an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_ring;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Saturating edge counters; overflow flags a lost edge at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (w_measure) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_edge[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Entropy shifter: a word is published only when all RND_W bits came from one window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_rnd       <= '0;
            r_rnd_valid <= 1'b0;
        end else begin
            r_rnd_valid <= 1'b0;
            if (w_accept) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_measure) begin
                r_shift <= w_word[RND_W-2:0];
                if (r_bitcnt == BIT_LAST) begin
                    r_bitcnt    <= '0;
                    r_rnd       <= w_word;
                    r_rnd_valid <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + BC_W'(1);
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign counts    = r_cnt;
    assign overflow  = r_ovf;
    assign rnd       = r_rnd;
    assign rnd_valid = r_rnd_valid;
endmodule
